// File: rtl/core_bus_bridge.sv
// ----------------------------------------------------------------------------
// core_bus_bridge
//
// Bus-clock-domain endpoint for a half-rate core. The core clock is clk_i
// divided by two; this block regenerates that phase internally and uses it to
// decide when core_req_i may be sampled.
//
// A request is captured only on a "mid edge" (phase==1 before the edge). That
// is the half of the core cycle in which the core's outputs are stable. Each
// captured request becomes one classic Wishbone cycle. The response is then
// held until the next "core edge" (phase==0 before the edge), so the core
// samples it exactly once.
//
// Optional feature, selected by the BUS_TIMEOUT_EN macro:
//   defined   - a bus cycle that gets no ack/err within TIMEOUT bus clocks is
//               aborted and answered as an error
//   undefined - the bridge waits for the slave indefinitely; TIMEOUT is unused
//
// Parameters
//   ADDR_WIDTH   address width
//   DATA_WIDTH   data width; byte-select width is DATA_WIDTH/8
//   TIMEOUT      bus clocks before abort (BUS_TIMEOUT_EN only)
//
// Ports
//   clk_i, rst_i          bus clock, asynchronous active-high reset
//   core_req_i            core request, held for whole core cycles
//   core_we_i             1 = write
//   core_addr_i           request address
//   core_dat_i            write data
//   core_sel_i            byte selects
//   core_dat_o            read data, valid with core_ready_o
//   core_ready_o          response valid
//   core_err_o            response is an error, valid with core_ready_o
//   wb_cyc_o, wb_stb_o    bus cycle / strobe (always equal)
//   wb_we_o               bus write
//   wb_adr_o              bus address
//   wb_dat_o              bus write data
//   wb_sel_o              bus byte selects
//   wb_dat_i              bus read data
//   wb_ack_i, wb_err_i    bus termination
// ----------------------------------------------------------------------------
module core_bus_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    core_req_i,
  input  logic                    core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_dat_i,
  input  logic [DATA_WIDTH/8-1:0] core_sel_i,
  output logic [DATA_WIDTH-1:0]   core_dat_o,
  output logic                    core_ready_o,
  output logic                    core_err_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  // phase==0 before an edge marks a core rising edge; phase==1 a mid edge.
  logic phase;

  logic accept;        // capture the core request and open a bus cycle
  logic term_ack;      // normal termination
  logic term_err;      // error termination (slave error or timeout)
  logic release_hold;  // core has sampled the response
  logic tmo_hit;       // bus cycle has run out of time

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    term_ack     = 1'b0;
    term_err     = 1'b0;
    release_hold = 1'b0;
    case (state)
      IDLE: begin
        // Only the mid edge sees the core's request in its stable half.
        if (phase && core_req_i) begin
          accept    = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        // A real termination always beats the timeout, and err beats ack.
        if (wb_err_i) begin
          term_err  = 1'b1;
          state_nxt = HOLD;
        end else if (wb_ack_i) begin
          term_ack  = 1'b1;
          state_nxt = HOLD;
        end else if (tmo_hit) begin
          term_err  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Leaving on the core edge means that edge samples the response and
        // the next acceptance can happen no earlier than the following mid
        // edge, so one core cycle never yields two bus cycles.
        if (!phase) begin
          release_hold = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, phase and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      phase        <= 1'b0;
      wb_cyc_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      core_dat_o   <= '0;
      core_ready_o <= 1'b0;
      core_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= ~phase;

      if (accept) begin
        wb_cyc_o <= 1'b1;
        wb_we_o  <= core_we_i;
        wb_adr_o <= core_addr_i;
        wb_dat_o <= core_dat_i;
        wb_sel_o <= core_sel_i;
      end

      if (term_ack || term_err) begin
        wb_cyc_o     <= 1'b0;
        core_ready_o <= 1'b1;
        core_err_o   <= term_err;
      end

      // Writes and errored reads leave the last read data in place.
      if (term_ack && !wb_we_o) begin
        core_dat_o <= wb_dat_i;
      end

      if (release_hold) begin
        core_ready_o <= 1'b0;
        core_err_o   <= 1'b0;
      end
    end
  end

  assign wb_stb_o = wb_cyc_o;

  // --------------------------------------------------------------------------
  // Optional bus timeout
  // --------------------------------------------------------------------------
`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts completed BUS cycles; the TIMEOUT-th one aborts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == BUS) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;

  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

endmodule

// File: tb/tb_core_bus_bridge.sv
`timescale 1ns/1ps
module tb_core_bus_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;
`ifdef BUS_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  localparam int SL_SILENT = 0;
  localparam int SL_WAIT   = 1;
  localparam int SL_RANDOM = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_req  = 1'b0;
  logic          core_we   = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdat = '0;
  logic [SW-1:0] core_sel  = '0;
  logic [DW-1:0] core_rdat;
  logic          core_ready;
  logic          core_err;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_wdat;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_rdat = '0;
  logic          wb_ack  = 1'b0;
  logic          wb_err  = 1'b0;

  core_bus_bridge #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .core_req_i  (core_req),
    .core_we_i   (core_we),
    .core_addr_i (core_addr),
    .core_dat_i  (core_wdat),
    .core_sel_i  (core_sel),
    .core_dat_o  (core_rdat),
    .core_ready_o(core_ready),
    .core_err_o  (core_err),
    .wb_cyc_o    (wb_cyc),
    .wb_stb_o    (wb_stb),
    .wb_we_o     (wb_we),
    .wb_adr_o    (wb_adr),
    .wb_dat_o    (wb_wdat),
    .wb_sel_o    (wb_sel),
    .wb_dat_i    (wb_rdat),
    .wb_ack_i    (wb_ack),
    .wb_err_i    (wb_err)
  );

  always #5 clk = ~clk;

  // Reference model: one transfer in flight at a time, response shown until
  // the next core edge, requests taken only on odd edges since reset.
  int unsigned   m_edge;
  logic          m_open, m_resp, m_err;
  int unsigned   m_wait;
  logic          m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat, m_rdata;
  logic [SW-1:0] m_sel;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edge <= 0; m_open <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0;
      m_wait <= 0; m_we <= 1'b0; m_adr <= '0; m_dat <= '0; m_sel <= '0;
      m_rdata <= '0;
    end else begin
      if (m_resp) begin
        if (m_edge[0] == 1'b0) begin
          m_resp <= 1'b0;
          m_err  <= 1'b0;
        end
      end else if (m_open) begin
        m_wait <= m_wait + 1;
        if (wb_err) begin
          m_open <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1;
        end else if (wb_ack) begin
          m_open <= 1'b0; m_resp <= 1'b1; m_err <= 1'b0;
          if (!m_we) m_rdata <= wb_rdat;
        end else if (TMO_ON && (m_wait + 1 == TMO)) begin
          m_open <= 1'b0; m_resp <= 1'b1; m_err <= 1'b1;
        end
      end else if (m_edge[0] && core_req) begin
        m_open <= 1'b1; m_wait <= 0;
        m_we <= core_we; m_adr <= core_addr; m_dat <= core_wdat; m_sel <= core_sel;
      end
      m_edge <= m_edge + 1;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  int smode = SL_SILENT;
  int swait = 0;
  int wcnt  = 0;
  logic s_err = 1'b0;
  logic [DW-1:0] s_rdata = '0;

  int   cyc_starts, cyc_cycles, rdy_edges, err_edges;
  logic prev_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    cyc_starts = 0; cyc_cycles = 0; rdy_edges = 0; err_edges = 0;
    prev_cyc = 1'b0; wcnt = 0;
  endtask

  // One bus clock: compare at the falling edge, then let the slave react.
  task automatic step();
    @(negedge clk);
    chk("cyc",   {63'd0, wb_cyc},     {63'd0, m_open});
    chk("stb",   {63'd0, wb_stb},     {63'd0, m_open});
    chk("ready", {63'd0, core_ready}, {63'd0, m_resp});
    chk("err",   {63'd0, core_err},   {63'd0, m_resp & m_err});
    chk("rdata", 64'(core_rdat),      64'(m_rdata));
    if (m_open) begin
      chk("wb_we",  {63'd0, wb_we}, {63'd0, m_we});
      chk("wb_adr", 64'(wb_adr),    64'(m_adr));
      chk("wb_dat", 64'(wb_wdat),   64'(m_dat));
      chk("wb_sel", 64'(wb_sel),    64'(m_sel));
    end
    if (core_ready && m_edge[0] == 1'b0) rdy_edges++;
    if (core_ready && core_err && m_edge[0] == 1'b0) err_edges++;
    if (wb_cyc) cyc_cycles++;
    if (wb_cyc && !prev_cyc) begin
      cyc_starts++;
      // The edge that opened the cycle is odd, so the count is now even.
      chk("start_on_mid", 64'(m_edge[0]), 64'd0);
    end
    prev_cyc = wb_cyc;
    case (smode)
      SL_WAIT: begin
        wb_rdat = s_rdata;
        if (wb_cyc) begin
          if (wcnt == swait) begin
            wb_ack = 1'b1; wb_err = s_err;
          end else begin
            wb_ack = 1'b0; wb_err = 1'b0; wcnt++;
          end
        end else begin
          wb_ack = 1'b0; wb_err = 1'b0; wcnt = 0;
        end
      end
      SL_RANDOM: begin
        wb_ack  = ($urandom % 3) == 0;
        wb_err  = ($urandom % 10) == 0;
        wb_rdat = $urandom;
      end
      default: begin
        wb_ack = 1'b0; wb_err = 1'b0;
      end
    endcase
  endtask

  task automatic core_read(input logic [AW-1:0] a);
    core_req = 1'b1; core_we = 1'b0; core_addr = a; core_sel = 4'hF;
    core_wdat = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cyc",   {63'd0, wb_cyc},     64'd0);
    chk("rst_ready", {63'd0, core_ready}, 64'd0);
    chk("rst_rdata", 64'(core_rdat),      64'd0);
    chk("rst_adr",   64'(wb_adr),         64'd0);
    rst = 1'b0;
    step();   // first edge after reset is a core edge; now aligned

    // Zero-wait read: issue, see the response one core cycle later.
    smode = SL_WAIT; swait = 0; s_err = 1'b0; s_rdata = 32'hDEADBEEF;
    clear_mon();
    core_read(32'h100);
    repeat (4) step();
    core_req = 1'b0;
    repeat (4) step();
    chk("zw_starts", 64'(cyc_starts), 64'd1);
    chk("zw_cycles", 64'(cyc_cycles), 64'd1);
    chk("zw_rdata",  64'(core_rdat),  64'hDEADBEEF);
    chk("zw_ready_edges", 64'(rdy_edges), 64'd1);
    chk("zw_err_edges",   64'(err_edges), 64'd0);

    // Write with three wait states.
    clear_mon(); swait = 3; s_rdata = 32'h0;
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h200;
    core_wdat = 32'h12345678; core_sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wb_cyc) begin
        chk("wr_adr", 64'(wb_adr),  64'h200);
        chk("wr_dat", 64'(wb_wdat), 64'h12345678);
        chk("wr_sel", 64'(wb_sel),  64'hF);
        chk("wr_we",  {63'd0, wb_we}, 64'd1);
      end
    end
    core_req = 1'b0;
    repeat (2) step();
    chk("wr_cycles", 64'(cyc_cycles), 64'd4);
    chk("wr_starts", 64'(cyc_starts), 64'd1);
    chk("wr_rdata_kept", 64'(core_rdat), 64'hDEADBEEF);
    chk("wr_ready_edges", 64'(rdy_edges), 64'd1);

    // ack and err together: error response, read data untouched.
    clear_mon(); swait = 0; s_err = 1'b1; s_rdata = 32'hCAFEF00D;
    core_read(32'h300);
    repeat (4) step();
    core_req = 1'b0;
    repeat (2) step();
    chk("er_err_edges",   64'(err_edges), 64'd1);
    chk("er_ready_edges", 64'(rdy_edges), 64'd1);
    chk("er_rdata_kept",  64'(core_rdat), 64'hDEADBEEF);

    // Held request: each transfer spans an issue and a response core cycle,
    // so five core cycles of request give three bus cycles.
    clear_mon(); s_err = 1'b0; s_rdata = 32'h0BADF00D;
    core_read(32'h400);
    repeat (10) step();
    core_req = 1'b0;
    repeat (4) step();
    chk("b2b_starts", 64'(cyc_starts), 64'd3);
    chk("b2b_ready_edges", 64'(rdy_edges), 64'd3);
    chk("b2b_rdata", 64'(core_rdat), 64'h0BADF00D);

    // Random traffic; core inputs change only at core-cycle boundaries.
    smode = SL_RANDOM;
    for (int c = 0; c < 400; c++) begin
      core_req  = ($urandom % 3) != 0;
      core_we   = $urandom % 2;
      core_addr = $urandom;
      core_wdat = $urandom;
      core_sel  = 4'($urandom);
      repeat (2) step();
    end
    core_req = 1'b0; smode = SL_WAIT; swait = 0; s_err = 1'b0; wcnt = 0;
    repeat (6) step();

    // Silent slave.
    clear_mon(); smode = SL_SILENT;
    core_read(32'h500);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      step();
      if (cyc_starts > 0 && !wb_cyc) break;
    end
    core_req = 1'b0;
    chk("tmo_cycles", 64'(cyc_cycles), 64'(TMO));
    chk("tmo_ready",  {63'd0, core_ready}, 64'd1);
    chk("tmo_err",    {63'd0, core_err},   64'd1);
    repeat (4) step();
    core_req = 1'b1;
`else
    repeat (100) step();
    chk("hang_cycles", 64'(cyc_cycles), 64'd100);
`endif

    // Asynchronous reset in the middle of a bus cycle.
    for (int i = 0; i < 8 && !wb_cyc; i++) step();
    chk("bus_entry", {63'd0, wb_cyc}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc",   {63'd0, wb_cyc},     64'd0);
    chk("arst_stb",   {63'd0, wb_stb},     64'd0);
    chk("arst_ready", {63'd0, core_ready}, 64'd0);
    chk("arst_err",   {63'd0, core_err},   64'd0);
    chk("arst_rdata", 64'(core_rdat),      64'd0);
    chk("arst_adr",   64'(wb_adr),         64'd0);
    core_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();

    // Phase restarts at 0: a fresh read must again open on a mid edge.
    clear_mon(); smode = SL_WAIT; swait = 0; s_err = 1'b0; s_rdata = 32'h5A5A5A5A;
    core_read(32'h600);
    repeat (4) step();
    core_req = 1'b0;
    repeat (4) step();
    chk("post_rst_starts", 64'(cyc_starts), 64'd1);
    chk("post_rst_rdata",  64'(core_rdat),  64'h5A5A5A5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
